// File: rtl/mriscv_axil_mem.sv
// AXI4-Lite single-port word memory: independent write (AW/W/B) and read (AR/R)
// channels, byte strobes, address aliasing by word index, registered read data.
module mriscv_axil_mem #(
   parameter int AW_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        AWvalid,
   output logic        AWready,
   input  logic [31:0] AWdata,
   input  logic [2:0]  AWprot,
   input  logic        Wvalid,
   output logic        Wready,
   input  logic [31:0] Wdata,
   input  logic [3:0]  Wstrb,
   output logic        Bvalid,
   input  logic        Bready,
   input  logic        ARvalid,
   output logic        ARready,
   input  logic [31:0] ARdata,
   input  logic [2:0]  ARprot,
   output logic        Rvalid,
   input  logic        RReady,
   output logic [31:0] Rdata
);

   localparam int DEPTH = 1 << AW_WORDS;

   typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wrState_e;
   typedef enum logic {RD_IDLE, RD_RESP} rdState_e;

   wrState_e              wrState_q, wrState_d;
   rdState_e              rdState_q, rdState_d;
   logic [AW_WORDS-1:0]   awIdx_q, awIdx_d;
   logic [31:0]           wData_q, wData_d;
   logic [3:0]            wStrb_q, wStrb_d;
   logic [31:0]           rdata_q, rdata_d;

   logic                  commitEn;
   logic [AW_WORDS-1:0]   commitIdx;
   logic [31:0]           commitData;
   logic [3:0]            commitStrb;

   // Contents survive reset; only the power-up image is zero.
   logic [31:0]           mem_q [DEPTH] = '{default: 32'h0};

   logic                  unusedOk;
   assign unusedOk = ^{AWprot, ARprot, AWdata[1:0], ARdata[1:0],
                       AWdata[31:AW_WORDS+2], ARdata[31:AW_WORDS+2]};

   always_comb begin
      wrState_d  = wrState_q;
      awIdx_d    = awIdx_q;
      wData_d    = wData_q;
      wStrb_d    = wStrb_q;
      commitEn   = 1'b0;
      commitIdx  = awIdx_q;
      commitData = wData_q;
      commitStrb = wStrb_q;
      AWready    = 1'b0;
      Wready     = 1'b0;
      Bvalid     = 1'b0;
      case (wrState_q)
         WR_IDLE: begin
            AWready = 1'b1;
            Wready  = 1'b1;
            if (AWvalid && Wvalid) begin
               commitEn   = 1'b1;
               commitIdx  = AWdata[AW_WORDS+1:2];
               commitData = Wdata;
               commitStrb = Wstrb;
               wrState_d  = WR_RESP;
            end else if (AWvalid) begin
               awIdx_d   = AWdata[AW_WORDS+1:2];
               wrState_d = WR_WAIT_W;
            end else if (Wvalid) begin
               wData_d   = Wdata;
               wStrb_d   = Wstrb;
               wrState_d = WR_WAIT_AW;
            end
         end
         WR_WAIT_W: begin
            Wready = 1'b1;
            if (Wvalid) begin
               commitEn   = 1'b1;
               commitData = Wdata;
               commitStrb = Wstrb;
               wrState_d  = WR_RESP;
            end
         end
         WR_WAIT_AW: begin
            AWready = 1'b1;
            if (AWvalid) begin
               commitEn  = 1'b1;
               commitIdx = AWdata[AW_WORDS+1:2];
               wrState_d = WR_RESP;
            end
         end
         WR_RESP: begin
            Bvalid = 1'b1;
            if (Bready) wrState_d = WR_IDLE;
         end
         default: wrState_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrState_q <= WR_IDLE;
         awIdx_q   <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
      end else begin
         wrState_q <= wrState_d;
         awIdx_q   <= awIdx_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
      end
   end

   always_ff @(posedge clk) begin
      if (commitEn) begin
         for (int i = 0; i < 4; i++) begin
            if (commitStrb[i]) mem_q[commitIdx][8*i +: 8] <= commitData[8*i +: 8];
         end
      end
   end

   // Read data is captured from the pre-commit array, so a colliding write is not seen.
   always_comb begin
      rdState_d = rdState_q;
      rdata_d   = rdata_q;
      ARready   = 1'b0;
      Rvalid    = 1'b0;
      case (rdState_q)
         RD_IDLE: begin
            ARready = 1'b1;
            if (ARvalid) begin
               rdata_d   = mem_q[ARdata[AW_WORDS+1:2]];
               rdState_d = RD_RESP;
            end
         end
         RD_RESP: begin
            Rvalid = 1'b1;
            if (RReady) rdState_d = RD_IDLE;
         end
         default: rdState_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdState_q <= RD_IDLE;
         rdata_q   <= '0;
      end else begin
         rdState_q <= rdState_d;
         rdata_q   <= rdata_d;
      end
   end

   assign Rdata = rdata_q;

endmodule

// File: tb/tb_mriscv_axil_mem.sv
// Directed bench for mriscv_axil_mem: a word-array memory model plus expected
// handshake levels, compared against the DUT on every falling clock edge.
module tb_mriscv_axil_mem;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        AWvalid, Wvalid, Bready, ARvalid, RReady;
   logic        AWready, Wready, Bvalid, ARready, Rvalid;
   logic [31:0] AWdata, Wdata, ARdata, Rdata;
   logic [2:0]  AWprot, ARprot;
   logic [3:0]  Wstrb;

   int          checks = 0;
   int          errors = 0;
   logic        checkEn = 1'b0;
   logic        expAwReady, expWready, expBvalid, expArReady, expRvalid;
   logic [31:0] expRdata;
   logic [31:0] modelMem [DEPTH];
   logic [31:0] got;

   mriscv_axil_mem #(.AW_WORDS(8)) dut (
      .clk(clk), .rst(rst),
      .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .AWprot(AWprot),
      .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
      .Bvalid(Bvalid), .Bready(Bready),
      .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
      .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata)
   );

   always #5 clk = ~clk;

   function automatic int modelIdx(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   task automatic writeModel(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      modelMem[modelIdx(addr)] = (modelMem[modelIdx(addr)] & ~mask) | (data & mask);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("AWready", {31'b0, AWready}, {31'b0, expAwReady});
         checkOutput("Wready",  {31'b0, Wready},  {31'b0, expWready});
         checkOutput("Bvalid",  {31'b0, Bvalid},  {31'b0, expBvalid});
         checkOutput("ARready", {31'b0, ARready}, {31'b0, expArReady});
         checkOutput("Rvalid",  {31'b0, Rvalid},  {31'b0, expRvalid});
         if (expRvalid) checkOutput("Rdata", Rdata, expRdata);
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input int awDelay, input int wDelay, input int bHold);
      bit awDone = 0;
      bit wDone = 0;
      int cyc = 0;
      while (!(awDone && wDone)) begin
         AWvalid = !awDone && (cyc >= awDelay);
         Wvalid  = !wDone && (cyc >= wDelay);
         AWdata  = addr;
         Wdata   = data;
         Wstrb   = strb;
         expAwReady = !awDone;
         expWready  = !wDone;
         @(posedge clk); #1;
         if (AWvalid) awDone = 1;
         if (Wvalid) wDone = 1;
         cyc++;
      end
      AWvalid = 1'b0;
      Wvalid  = 1'b0;
      writeModel(addr, data, strb);
      expAwReady = 1'b0;
      expWready  = 1'b0;
      expBvalid  = 1'b1;
      repeat (bHold) begin @(posedge clk); #1; end
      Bready = 1'b1;
      @(posedge clk); #1;
      Bready = 1'b0;
      expBvalid  = 1'b0;
      expAwReady = 1'b1;
      expWready  = 1'b1;
   endtask

   task automatic startRead(input logic [31:0] addr);
      ARvalid = 1'b1;
      ARdata  = addr;
      @(posedge clk); #1;
      ARvalid    = 1'b0;
      expRdata   = modelMem[modelIdx(addr)];
      expRvalid  = 1'b1;
      expArReady = 1'b0;
   endtask

   task automatic finishRead(input int rHold, output logic [31:0] data);
      repeat (rHold) begin @(posedge clk); #1; end
      data   = Rdata;
      RReady = 1'b1;
      @(posedge clk); #1;
      RReady     = 1'b0;
      expRvalid  = 1'b0;
      expArReady = 1'b1;
   endtask

   task automatic doRead(input logic [31:0] addr, input int rHold, output logic [31:0] data);
      startRead(addr);
      finishRead(rHold, data);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d1;
      foreach (modelMem[i]) modelMem[i] = 32'h0;
      rst = 1'b1;
      AWvalid = 0; Wvalid = 0; Bready = 0; ARvalid = 0; RReady = 0;
      AWdata = 0; Wdata = 0; Wstrb = 0; ARdata = 0;
      AWprot = 3'b010; ARprot = 3'b101;
      #1;
      checkOutput("rstBvalid",  {31'b0, Bvalid},  32'h0);
      checkOutput("rstRvalid",  {31'b0, Rvalid},  32'h0);
      checkOutput("rstRdata",   Rdata,            32'h0);
      checkOutput("rstAWready", {31'b0, AWready}, 32'h1);
      checkOutput("rstWready",  {31'b0, Wready},  32'h1);
      checkOutput("rstARready", {31'b0, ARready}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expAwReady = 1; expWready = 1; expBvalid = 0; expArReady = 1; expRvalid = 0; expRdata = 0;
      checkEn = 1'b1;

      applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      doRead(32'h10, 0, got);
      checkOutput("rd10", got, 32'hDEADBEEF);

      applyStimulus(32'h20, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      applyStimulus(32'h20, 32'h11223344, 4'b0101, 0, 3, 0);
      doRead(32'h20, 0, got);
      checkOutput("rd20strb", got, 32'hAA22CC44);

      applyStimulus(32'h24, 32'h12345678, 4'b0011, 2, 0, 0);
      doRead(32'h24, 0, got);
      checkOutput("rd24wFirst", got, 32'h00005678);

      applyStimulus(32'h20, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
      doRead(32'h20, 0, got);
      checkOutput("rd20strb0", got, 32'hAA22CC44);

      fork
         applyStimulus(32'h28, 32'h0A0B0C0D, 4'hF, 0, 0, 5);
         doRead(32'h10, 5, d1);
      join
      checkOutput("rdStall", d1, 32'hDEADBEEF);
      doRead(32'h28, 0, got);
      checkOutput("rd28", got, 32'h0A0B0C0D);

      applyStimulus(32'h400, 32'h12345678, 4'hF, 0, 0, 0);
      doRead(32'h0, 0, got);
      checkOutput("rdWrap0", got, 32'h12345678);
      doRead(32'h403, 0, got);
      checkOutput("rdWrap403", got, 32'h12345678);

      // Read and write commit to the same word on one edge.
      AWvalid = 1; AWdata = 32'h30; Wvalid = 1; Wdata = 32'hFFFFFFFF; Wstrb = 4'hF;
      ARvalid = 1; ARdata = 32'h30;
      @(posedge clk); #1;
      AWvalid = 0; Wvalid = 0; ARvalid = 0;
      expRdata = modelMem[modelIdx(32'h30)];
      writeModel(32'h30, 32'hFFFFFFFF, 4'hF);
      expRvalid = 1; expArReady = 0; expBvalid = 1; expAwReady = 0; expWready = 0;
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("rdCollide", Rdata, 32'h0);
      Bready = 1; RReady = 1;
      @(posedge clk); #1;
      Bready = 0; RReady = 0;
      expRvalid = 0; expArReady = 1; expBvalid = 0; expAwReady = 1; expWready = 1;
      doRead(32'h30, 0, got);
      checkOutput("rdAfterCollide", got, 32'hFFFFFFFF);

      startRead(32'h44);
      applyStimulus(32'h44, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      finishRead(1, got);
      checkOutput("rdHoldOld", got, 32'h0);
      doRead(32'h44, 0, got);
      checkOutput("rd44", got, 32'hCAFEF00D);

      // Reset while the write response is pending.
      AWvalid = 1; AWdata = 32'h60; Wvalid = 1; Wdata = 32'h55; Wstrb = 4'hF;
      @(posedge clk); #1;
      AWvalid = 0; Wvalid = 0;
      writeModel(32'h60, 32'h55, 4'hF);
      expBvalid = 1; expAwReady = 0; expWready = 0;
      #6;
      checkEn = 0;
      rst = 1;
      #1;
      checkOutput("midRstBvalid", {31'b0, Bvalid}, 32'h0);
      checkOutput("midRstRdata", Rdata, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      expBvalid = 0; expAwReady = 1; expWready = 1;
      checkEn = 1;
      checkOutput("relAWready", {31'b0, AWready}, 32'h1);
      checkOutput("relWready",  {31'b0, Wready},  32'h1);
      checkOutput("relARready", {31'b0, ARready}, 32'h1);
      doRead(32'h60, 0, got);
      checkOutput("rd60", got, 32'h55);

      // Reset while waiting for write data: the latched address must be dropped.
      AWvalid = 1; AWdata = 32'h70;
      @(posedge clk); #1;
      AWvalid = 0;
      expAwReady = 0; expWready = 1;
      #2;
      checkEn = 0;
      rst = 1;
      #1;
      rst = 0;
      expAwReady = 1; expWready = 1;
      checkEn = 1;
      @(posedge clk); #1;
      applyStimulus(32'h74, 32'h77, 4'hF, 2, 0, 0);
      doRead(32'h70, 0, got);
      checkOutput("rd70dropped", got, 32'h0);
      doRead(32'h74, 0, got);
      checkOutput("rd74", got, 32'h77);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mriscv_axil_mem.md
MRISCV_AXIL_MEM -- requirements
Module: mriscv_axil_mem

Interface
REQ-001 SHALL have parameter: AW_WORDS, 8, log2 of memory depth in 32-bit words (256 words default).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: AWvalid  input  1  write-address valid from core.
REQ-005 SHALL have port: AWready  output  1  write-address ready.
REQ-006 SHALL have port: AWdata  input  32  write byte address.
REQ-007 SHALL have port: AWprot  input  3  protection, ignored.
REQ-008 SHALL have port: Wvalid  input  1  write-data valid.
REQ-009 SHALL have port: Wready  output  1  write-data ready.
REQ-010 SHALL have port: Wdata  input  32  write data.
REQ-011 SHALL have port: Wstrb  input  4  byte enables, bit i covers Wdata[8i+7:8i].
REQ-012 SHALL have port: Bvalid  output  1  write response valid.
REQ-013 SHALL have port: Bready  input  1  write response accepted.
REQ-014 SHALL have port: ARvalid  input  1  read-address valid.
REQ-015 SHALL have port: ARready  output  1  read-address ready.
REQ-016 SHALL have port: ARdata  input  32  read byte address.
REQ-017 SHALL have port: ARprot  input  3  protection, ignored.
REQ-018 SHALL have port: Rvalid  output  1  read data valid.
REQ-019 SHALL have port: RReady  input  1  read data accepted.
REQ-020 SHALL have port: Rdata  output  32  read data.

Function
REQ-021 SHALL index memory by address bits [AW_WORDS+1:2]; bits [1:0] and upper bits ignored (aliasing wrap-around, no error response).
REQ-022 SHALL run write FSM states WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP.
REQ-023 SHALL drive AWready=1 only in WR_IDLE/WR_WAIT_AW, Wready=1 only in WR_IDLE/WR_WAIT_W, both combinational from state.
REQ-024 WR_IDLE: AW and W handshakes same cycle -> commit write at that edge, go WR_RESP; AW only -> latch address, go WR_WAIT_W; W only -> latch data/strobe, go WR_WAIT_AW.
REQ-025 WR_WAIT_W on W handshake, or WR_WAIT_AW on AW handshake -> commit write using latched plus incoming fields, go WR_RESP.
REQ-026 SHALL assert Bvalid exactly in WR_RESP (one cycle after final handshake); Bvalid&Bready -> WR_IDLE; Bvalid held until Bready.
REQ-027 SHALL update only bytes with Wstrb bit set; Wstrb=4'h0 leaves memory unchanged but still completes with Bvalid.
REQ-028 SHALL run read FSM states RD_IDLE, RD_RESP independent of write FSM; ARready=1 only in RD_IDLE.
REQ-029 RD_IDLE ARvalid -> register Rdata from memory at that edge, go RD_RESP; Rvalid=1 in RD_RESP; Rvalid&RReady -> RD_IDLE.
REQ-030 SHALL hold Rdata stable while Rvalid=1, even if a write to the same word commits meanwhile.
REQ-031 AR handshake and write commit to same word on same edge SHALL return pre-write contents.
REQ-032 SHALL allow at most one outstanding write and one outstanding read; back-to-back: next handshake no earlier than cycle after B/R handshake.

Reset
REQ-033 On rst=1 SHALL force WR_IDLE, RD_IDLE, Bvalid=0, Rvalid=0, Rdata=32'h0, latched address/data/strobe=0 immediately (no clock required).
REQ-034 Reset mid-transaction SHALL discard in-flight transaction: no response issued; no write committed unless commit edge preceded reset assertion.
REQ-035 Memory array contents SHALL be unaffected by reset and SHALL be zero at simulation start.

Verification
REQ-036 Reset: rst=1 mid WR_RESP -> Bvalid=0 same cycle, AWready=Wready=ARready=1 after release.
REQ-037 Write addr 0x10 data 0xDEADBEEF strb 4'hF, AW/W same cycle -> Bvalid next cycle; read 0x10 -> Rvalid next cycle, Rdata=0xDEADBEEF.
REQ-038 AW 0x20 three cycles before W 0x11223344 strb 4'b0101 over prior 0xAABBCCDD -> AWready low while waiting; read 0x20 returns 0xAA22CC44.
REQ-039 Bready and RReady held low 5 cycles -> Bvalid/Rvalid and Rdata stable, AWready/Wready/ARready low throughout.
REQ-040 Wrap: write 0x400 (AW_WORDS=8) 0x12345678, read 0x0 -> 0x12345678; read 0x403 -> same word.
REQ-041 AR 0x30 on same edge as write commit 0x30 (old 0x0, new 0xFFFFFFFF) -> Rdata=0x0; subsequent read -> 0xFFFFFFFF.
